// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the LSU bus master: access
//                size encoding, FSM state encoding, the default WAIT timeout
//                and the request legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size as presented on req_size; 2'd3 is deliberately not a member
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Bus master FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Default number of WAIT cycles tolerated before a timeout abort
    localparam int c_timeout_cycles_def = 15;

    // A request is illegal for size 3 or a misaligned half/word address
    function automatic logic is_illegal(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == 2'd3) begin
            bad = 1'b1;
        end else if (size == SZ_H) begin
            bad = addr_lo[0];
        end else if (size == SZ_W) begin
            bad = (addr_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane steering. Store side produces byte
//                enables and lane-replicated write data; load side extracts
//                the addressed lane and sign/zero-extends it.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  size_t       i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  size_t       i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shifted;

    // Bring the addressed byte lane down to bit 0
    assign w_ld_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

    // Store lane steering: replicate the datum so every enabled lane sees it
    always_comb begin
        o_st_be    = 4'b0000;
        o_st_wdata = 32'h0000_0000;
        case (i_st_size)
            SZ_B: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_H: begin
                o_st_be    = 4'b0011 << i_st_addr_lo;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            SZ_W: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_wdata;
            end
            default: begin
                o_st_be    = 4'b0000;
                o_st_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_ld_size)
            SZ_B: begin
                o_ld_data = i_ld_unsigned ? {24'h0, w_ld_shifted[7:0]}
                                          : {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            end
            SZ_H: begin
                o_ld_data = i_ld_unsigned ? {16'h0, w_ld_shifted[15:0]}
                                          : {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            end
            SZ_W: begin
                o_ld_data = i_ld_rdata;
            end
            default: begin
                o_ld_data = 32'h0000_0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_master
//  Description : Single-outstanding load/store bus master. Accepts one CPU
//                request, issues a one-cycle registered bus access, waits for
//                HREADY and holds the response until the CPU consumes it.
//                Optional macro LSU_TIMEOUT_EN adds a 4-bit WAIT counter that
//                aborts the access with rsp_err after TIMEOUT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles_def
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  HSEL,
    output logic                  HWRITE,
    output logic [3:0]            HBE,
    output logic [31:0]           HADDR,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY
);

    state_t      r_state;
    size_t       r_size;
    logic [1:0]  r_addr_lo;
    logic        r_unsigned;
    logic        r_write;

    size_t       w_req_size;
    logic [31:0] w_addr_ext;
    logic        w_req_illegal;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;
    logic        w_unused_addr;

`ifdef LSU_TIMEOUT_EN
    logic [3:0]  r_wait_cnt;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
`endif

    // Normalise the request address to 32 bits; only bits [27:2] reach the bus
    generate
        if (ADDR_WIDTH >= 32) begin : g_addr_trunc
            assign w_addr_ext = req_addr[31:0];
        end else begin : g_addr_pad
            assign w_addr_ext = {{(32-ADDR_WIDTH){1'b0}}, req_addr};
        end
    endgenerate

    // Upper address nibble is dropped on purpose; the access is still issued
    assign w_unused_addr = ^w_addr_ext[31:28];

    assign w_req_size    = size_t'(req_size);
    assign w_req_illegal = is_illegal(req_size, w_addr_ext[1:0]);

    // Store steering works off the live request, load extraction off the latch
    lsu_align u_align (
        .i_st_size     (w_req_size),
        .i_st_addr_lo  (w_addr_ext[1:0]),
        .i_st_wdata    (req_wdata),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (r_size),
        .i_ld_addr_lo  (r_addr_lo),
        .i_ld_unsigned (r_unsigned),
        .i_ld_rdata    (HRDATA),
        .o_ld_data     (w_ld_data)
    );

    // Transaction FSM with all CPU and bus outputs registered
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state    <= ST_IDLE;
            r_size     <= SZ_B;
            r_addr_lo  <= 2'b00;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            HSEL       <= 1'b0;
            HWRITE     <= 1'b0;
            HBE        <= 4'b0000;
            HADDR      <= 32'h0000_0000;
            HWDATA     <= 32'h0000_0000;
`ifdef LSU_TIMEOUT_EN
            r_wait_cnt <= 4'd0;
`endif
        end else begin
            // Bus signals live for exactly the ACCESS cycle and idle at zero
            HSEL   <= 1'b0;
            HWRITE <= 1'b0;
            HBE    <= 4'b0000;
            HADDR  <= 32'h0000_0000;
            HWDATA <= 32'h0000_0000;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (w_req_illegal) begin
                            // Reject without touching the bus
                            r_state   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else begin
                            r_state    <= ST_ACCESS;
                            r_size     <= w_req_size;
                            r_addr_lo  <= w_addr_ext[1:0];
                            r_unsigned <= req_unsigned;
                            r_write    <= req_write;
                            HSEL       <= 1'b1;
                            HWRITE     <= req_write;
                            HBE        <= req_write ? w_st_be : 4'b1111;
                            HADDR      <= {4'b0000, w_addr_ext[27:2], 2'b00};
                            HWDATA     <= req_write ? w_st_wdata : 32'h0000_0000;
                        end
                    end
                end

                ST_ACCESS: begin
                    r_state <= ST_WAIT;
`ifdef LSU_TIMEOUT_EN
                    r_wait_cnt <= 4'd0;
`endif
                end

                ST_WAIT: begin
                    if (HREADY) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= r_write ? 32'h0000_0000 : w_ld_data;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_wait_cnt == 4'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0000_0000;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
`endif
                end

                ST_RESP: begin
                    // Response is held until consumed; accept again next cycle
                    if (rsp_ready) begin
                        r_state   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0000_0000;
                        req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_bus_master
//  Description : Directed self-checking bench for lsu_bus_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_master;

    logic        HCLK;
    logic        HRESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic        HWRITE;
    logic [3:0]  HBE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    int n_checks;
    int n_errors;

    lsu_bus_master #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .HSEL         (HSEL),
        .HWRITE       (HWRITE),
        .HBE          (HBE),
        .HADDR        (HADDR),
        .HWDATA       (HWDATA),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    // Issue one request at a negedge and run until rsp_valid or budget expires.
    // The memory answers HREADY one cycle after HSEL when ack is set.
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic ack, input int budget,
                          output int lat, output int hsel_cyc,
                          output logic [3:0] be, output logic [31:0] haddr,
                          output logic [31:0] hwdata, output logic hwrite,
                          output logic [31:0] rdata, output logic err);
        logic prev_hsel;
        logic done;
        lat = 0; hsel_cyc = 0; be = 4'h0; haddr = 32'h0; hwdata = 32'h0;
        hwrite = 1'b0; rdata = 32'h0; err = 1'b0; prev_hsel = 1'b0; done = 1'b0;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            req_valid = 1'b0;
            lat++;
            if (HSEL) begin
                hsel_cyc++;
                be = HBE; haddr = HADDR; hwdata = HWDATA; hwrite = HWRITE;
            end
            if (rsp_valid) begin
                rdata = rsp_rdata; err = rsp_err; done = 1'b1;
            end
            HREADY = ack && prev_hsel;
            HRDATA = rd;
            prev_hsel = HSEL;
        end
        HREADY = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("consume_rsp_valid", rsp_valid, 0);
        check("consume_req_ready", req_ready, 1);
    endtask

    int          lat, hc;
    logic [3:0]  be;
    logic [31:0] ha, hw, rd;
    logic        hwr, er;

    initial begin
        n_checks = 0; n_errors = 0;
        HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b0; HRDATA = 32'h0; HREADY = 1'b0;
        repeat (3) @(negedge HCLK);

        // Reset state
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_hsel", HSEL, 0);
        check("rst_hbe", HBE, 0);
        check("rst_rdata", rsp_rdata, 0);
        HRESET = 1'b0;
        step();

        // SB 0x103
        do_txn(1, 2'd0, 0, 32'h103, 32'h0000_00A5, 32'h0, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("sb_hbe", be, 4'b1000);
        check("sb_hwdata", hw, 32'hA5A5_A5A5);
        check("sb_haddr", ha, 32'h100);
        check("sb_hwrite", hwr, 1);
        check("sb_hsel_cycles", hc, 1);
        check("sb_lat", lat, 3);
        check("sb_err", er, 0);
        check("sb_rdata", rd, 0);
        consume();

        // SH 0x2 replicates the low half onto both halves
        do_txn(1, 2'd1, 0, 32'h2, 32'hDEAD_BEEF, 32'h0, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("sh_hbe", be, 4'b1100);
        check("sh_hwdata", hw, 32'hBEEF_BEEF);
        check("sh_haddr", ha, 32'h0);
        consume();

        // SW with upper address nibble set: still issued, address truncated
        do_txn(1, 2'd2, 0, 32'hF000_0008, 32'h1234_5678, 32'h0, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("sw_hbe", be, 4'b1111);
        check("sw_hwdata", hw, 32'h1234_5678);
        check("sw_haddr", ha, 32'h0000_0008);
        check("sw_hsel_cycles", hc, 1);
        consume();

        // LB 0x2 signed
        do_txn(0, 2'd0, 0, 32'h2, 32'h0, 32'h12F0_3456, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("lb_rdata", rd, 32'hFFFF_FFF0);
        check("lb_lat", lat, 3);
        check("lb_hbe", be, 4'b1111);
        check("lb_hwrite", hwr, 0);
        check("lb_hwdata", hw, 0);
        check("lb_err", er, 0);

        // Back-pressure: response held stable for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'hFFFF_FFF0);
            check("bp_req_ready", req_ready, 0);
        end
        consume();

        // LBU 0x2
        do_txn(0, 2'd0, 1, 32'h2, 32'h0, 32'h12F0_3456, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("lbu_rdata", rd, 32'h0000_00F0);
        consume();

        // LH / LHU 0x2
        do_txn(0, 2'd1, 0, 32'h2, 32'h0, 32'h8001_1234, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("lh_rdata", rd, 32'hFFFF_8001);
        consume();
        do_txn(0, 2'd1, 1, 32'h2, 32'h0, 32'h8001_1234, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("lhu_rdata", rd, 32'h0000_8001);
        consume();

        // LW 0x4
        do_txn(0, 2'd2, 0, 32'h4, 32'h0, 32'hCAFE_BABE, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("lw_rdata", rd, 32'hCAFE_BABE);
        check("lw_haddr", ha, 32'h4);

        // A request presented while the response is consumed is not taken
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8;
        step();
        rsp_ready = 1'b0;
        check("b2b_no_accept_hsel", HSEL, 0);
        check("b2b_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("b2b_accept_hsel", HSEL, 1);
        check("b2b_accept_haddr", HADDR, 32'h8);
        step();
        HREADY = 1'b1; HRDATA = 32'h0BAD_F00D;
        step();
        HREADY = 1'b0;
        check("b2b_rsp_valid", rsp_valid, 1);
        check("b2b_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
        consume();

        // Illegal requests
        do_txn(0, 2'd2, 0, 32'h6, 32'h0, 32'hFFFF_FFFF, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("lw_mis_err", er, 1);
        check("lw_mis_hsel_cycles", hc, 0);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_rdata", rd, 0);
        consume();
        do_txn(0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("sz3_err", er, 1);
        check("sz3_hsel_cycles", hc, 0);
        consume();
        do_txn(1, 2'd1, 0, 32'h1, 32'h1234, 32'h0, 1, 20, lat, hc, be, ha, hw, hwr, rd, er);
        check("sh_mis_err", er, 1);
        check("sh_mis_hsel_cycles", hc, 0);
        consume();

        // Reset pulsed during ACCESS drops HSEL immediately
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0;
        step();
        req_valid = 1'b0;
        check("rsta_hsel_before", HSEL, 1);
        HRESET = 1'b1;
        #1;
        check("rsta_hsel_now", HSEL, 0);
        check("rsta_req_ready", req_ready, 1);
        @(negedge HCLK);
        HRESET = 1'b0;

        // Reset pulsed during WAIT discards the transaction
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'hC;
        step();
        req_valid = 1'b0;
        step();
        HREADY = 1'b1; HRDATA = 32'h1111_2222;
        HRESET = 1'b1;
        #1;
        check("rstw_hsel", HSEL, 0);
        check("rstw_rsp_valid", rsp_valid, 0);
        @(negedge HCLK);
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstw_no_rsp", rsp_valid, 0);
            check("rstw_req_ready", req_ready, 1);
        end
        HREADY = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // HREADY never arrives: abort after 15 WAIT cycles
        do_txn(0, 2'd2, 0, 32'h10, 32'h0, 32'hFFFF_FFFF, 0, 40, lat, hc, be, ha, hw, hwr, rd, er);
        check("to_lat", lat, 17);
        check("to_err", er, 1);
        check("to_rdata", rd, 0);
        consume();
`else
        // Without timeout the master waits as long as it takes
        do_txn(0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0, 30, lat, hc, be, ha, hw, hwr, rd, er);
        check("nto_still_waiting", lat, 32'hFFFF_FFFF);
        check("nto_hsel_cycles", hc, 1);
        HREADY = 1'b1; HRDATA = 32'h5566_7788;
        step();
        HREADY = 1'b0;
        check("nto_rsp_valid", rsp_valid, 1);
        check("nto_rsp_err", rsp_err, 0);
        check("nto_rsp_rdata", rsp_rdata, 32'h5566_7788);
        consume();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
